config_tx_link: RTL and testbench
=================================

// Module: config_tx_link
// PURPOSE
//  Serial configuration transmitter with an on-board 4x16-bit register bank.
//  - On a START rising edge, reads each register and shifts it out MSB-first as
//    a 24-bit word {5'b0, addr[2:0], data[15:0]}, one word per line slot.
//  - Drives a gated bit clock (TX_CLK), data (TX_DAT) and output-enable (TX_OE).
//  - Sits between the host register interface and the sensor/converter config link.
// PARAMETERS
//  CLOCK_PERIOD_PS  20833  system clock period, ps (48 MHz)
//  BIT_PERIOD_NS    400    serial bit period, ns (2.5 MHz)
//  C_NO_CFG_BITS    24     bits per transmitted word
//  C_NO_REGS        4      words per burst (addresses 0..C_NO_REGS-1)
// PORTS
//  CLOCK        in   1   system clock, all logic on rising edge
//  RESET        in   1   asynchronous, active-low reset
//  START        in   1   burst request; rising edge (synchronous detect) starts a burst
//  LINE_PERIOD  in   16  slot length per word, in CLOCK cycles
//  WE_A         in   1   host byte write enable
//  ADD_A        in   3   host byte address: [2:1] word, [0] 0=low byte, 1=high byte
//  DAT_A        in   8   host write data
//  TX_END       out  1   burst complete flag (level)
//  TX_DAT       out  1   serial data
//  TX_CLK       out  1   serial bit clock
//  TX_OE        out  1   output enable, high while a word is shifting
// BEHAVIOUR
//  - DIV = (BIT_PERIOD_NS*1000 + CLOCK_PERIOD_PS/2) / CLOCK_PERIOD_PS  (=19 at defaults).
//  - LO = DIV/2 (=9), HI = DIV-LO (=10).
//  - Reset values: TX_END=0, TX_DAT=0, TX_CLK=0, TX_OE=0, FSM=IDLE.
//  - Register reset values: R0=16'h8001, R1=16'h4002, R2=16'h2004, R3=16'h1008.
//  - Bank write: WE_A=1 writes DAT_A into the selected byte; visible on the next cycle.
//  - Bank read: 1-cycle registered latency.
//  - Read and write to the same word in the same cycle: the read returns the old value.
//  - START registered once; edge = START & ~START_q.
//  - An edge seen in IDLE or DONE starts a burst: TX_END clears and addr=0.
//  - Edges during a burst are ignored.
//  - SLOT = max(LINE_PERIOD, C_NO_CFG_BITS*DIV + 2); slot counter s runs 0..SLOT-1 per word.
//  - FSM states:
//    IDLE  -> READ  on edge.
//    READ  (s=0): internal RD_EN=1, RD_ADDR=addr.
//    LOAD  (s=1): shift reg <= {5'b0, addr, rd_data}.
//    SHIFT (s=2 .. 2+24*DIV-1):
//      - TX_OE=1, TX_DAT=shreg[23].
//      - Each bit: TX_CLK=0 for LO cycles, then 1 for HI cycles.
//      - Shift at the end of each bit, so data changes on TX_CLK falling edge.
//    GAP: TX_OE=0, TX_CLK=0, TX_DAT=0 until s=SLOT-1.
//      - At s=SLOT-1: if addr=C_NO_REGS-1 -> DONE, else addr+1 -> READ.
//    DONE: TX_END=1, held until the next accepted edge.
//  - TX_CLK, TX_DAT and TX_OE are registered outputs (glitch-free).
//  - Asserting RESET mid-burst aborts immediately: all outputs go to 0, FSM returns to IDLE.
//  - Register contents are preserved across a burst.
//  - Changing LINE_PERIOD mid-burst takes effect at the next slot boundary (latched at READ).
// STRUCTURE
//  - Package cfg_tx_pkg holds: state enum; DIV/LO/HI localparam functions;
//    header width (8); register reset-value constants.
//  - Sub-module cfg_reg_bank: 4x16 byte-writable bank, write port A and registered read port B.
//  - Serializer FSM lives in config_tx_link.
// TESTING
//  1. Reset, then START rising with LINE_PERIOD=4000:
//     - four words of 24 bits each.
//     - First word = 0x008001; the others 0x014002, 0x022004, 0x031008.
//     - TX_OE high for 456 cycles per word.
//     - Word starts 4000 cycles apart.
//     - TX_END rises 16000 cycles after burst start.
//  2. Bit timing: TX_CLK low 9 / high 10 cycles per bit; TX_DAT stable whenever TX_CLK=1.
//  3. Host writes ADD_A=3 DAT_A=8'hAB and ADD_A=2 DAT_A=8'hCD, then START:
//     - word1 = 0x01ABCD.
//  4. LINE_PERIOD=100 (below minimum):
//     - slot = 458 cycles.
//     - no overlap of words; TX_OE drops between words.
//  5. START held high 50 us, dropped 1 us, raised again:
//     - exactly one burst per edge.
//     - TX_END clears on the second edge.
//     - An edge mid-burst is ignored.
//  6. RESET asserted during word 2:
//     - all outputs 0 immediately.
//     - After release, a new START gives a full 4-word burst from addr 0.

Source files
------------

// File: rtl/config_tx_link_pkg.sv
// ---------------------------------------------------------------------------
// cfg_tx_pkg
// Shared types and constants for the serial configuration transmitter:
//   - tx_state_e   : serializer FSM states
//   - calc_div/lo/hi: bit-period divider arithmetic (rounded to nearest clock)
//   - HDR_W/ADDR_W/DATA_W: transmitted word layout {pad, addr, data}
//   - REG_RST      : power-on contents of the 4x16 register bank
// ---------------------------------------------------------------------------
package cfg_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } tx_state_e;

    localparam int HDR_W    = 8;   // zero pad + address field ahead of the data
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 4;

    localparam logic [NUM_REGS-1:0][DATA_W-1:0] REG_RST = {
        16'h1008, 16'h2004, 16'h4002, 16'h8001
    };

    // Clocks per serial bit, rounded to the nearest whole clock.
    function automatic int calc_div(input int bit_ns, input int clk_ps);
        return (bit_ns * 1000 + clk_ps / 2) / clk_ps;
    endfunction

    function automatic int calc_lo(input int div);
        return div / 2;
    endfunction

    function automatic int calc_hi(input int div);
        return div - div / 2;
    endfunction

endpackage

// File: rtl/config_tx_link_if.sv
// ---------------------------------------------------------------------------
// config_tx_link_if
// Bundles the host side (burst request, slot length, byte-write port) and the
// serial link side (TX_CLK/TX_DAT/TX_OE plus burst-done flag).
//   master : host / environment, drives requests and observes the link
//   slave  : config_tx_link
// ---------------------------------------------------------------------------
interface config_tx_link_if;
    logic        START;
    logic [15:0] LINE_PERIOD;
    logic        WE_A;
    logic [2:0]  ADD_A;
    logic [7:0]  DAT_A;
    logic        TX_END;
    logic        TX_DAT;
    logic        TX_CLK;
    logic        TX_OE;

    modport master (
        output START, LINE_PERIOD, WE_A, ADD_A, DAT_A,
        input  TX_END, TX_DAT, TX_CLK, TX_OE
    );

    modport slave (
        input  START, LINE_PERIOD, WE_A, ADD_A, DAT_A,
        output TX_END, TX_DAT, TX_CLK, TX_OE
    );
endinterface

// File: rtl/config_tx_link_reg_bank.sv
// ---------------------------------------------------------------------------
// cfg_reg_bank
// 4x16 register bank with a byte-wide host write port and a registered
// 16-bit read port.
//   gclk, grst_n : clock, async active-low reset (restores REG_RST)
//   we_a         : byte write enable
//   add_a        : [2:1] word, [0] byte select (1 = high byte)
//   dat_a        : write byte
//   rd_en        : read strobe, rd_data valid the following cycle
//   rd_addr      : word to read
//   rd_data      : registered read data (old contents on same-cycle write)
// ---------------------------------------------------------------------------
module cfg_reg_bank
    import cfg_tx_pkg::*;
(
    input  logic              gclk,
    input  logic              grst_n,
    input  logic              we_a,
    input  logic [2:0]        add_a,
    input  logic [7:0]        dat_a,
    input  logic              rd_en,
    input  logic [1:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            mem <= REG_RST;
        end else if (we_a) begin
            if (add_a[0]) mem[add_a[2:1]][15:8] <= dat_a;
            else          mem[add_a[2:1]][7:0]  <= dat_a;
        end
    end

    // Reads sample mem before this edge's write lands, so a colliding
    // write is seen only by the next read.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)    rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/config_tx_link.sv
// ---------------------------------------------------------------------------
// config_tx_link
// On a START rising edge, reads each bank register in turn and shifts it out
// MSB-first as {pad, addr, data}, one word per line slot.
//   CLOCK : system clock
//   RESET : async active-low reset, aborts any burst
//   bus   : config_tx_link_if.slave (START, LINE_PERIOD, host write port,
//           TX_END/TX_DAT/TX_CLK/TX_OE)
// Slot counter s runs 0..slot-1: s=0 READ, s=1 LOAD, then C_NO_CFG_BITS*DIV
// SHIFT cycles, then GAP until the slot ends. All link outputs are registered
// from the FSM state, so they trail the state by one clock uniformly.
// ---------------------------------------------------------------------------
module config_tx_link
    import cfg_tx_pkg::*;
#(
    parameter int CLOCK_PERIOD_PS = 20833,
    parameter int BIT_PERIOD_NS   = 400,
    parameter int C_NO_CFG_BITS   = 24,
    parameter int C_NO_REGS       = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    config_tx_link_if.slave  bus
);

    localparam int DIV = calc_div(BIT_PERIOD_NS, CLOCK_PERIOD_PS);
    localparam int LO  = calc_lo(DIV);
    localparam int HI  = calc_hi(DIV);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (C_NO_CFG_BITS > 1) ? $clog2(C_NO_CFG_BITS) : 1;

    localparam logic [15:0]        MIN_SLOT  = 16'(C_NO_CFG_BITS * DIV + 2);
    localparam logic [CW-1:0]      BIT_LAST  = CW'(LO + HI - 1);
    localparam logic [CW-1:0]      CLK_RISE  = CW'(LO);
    localparam logic [BW-1:0]      WORD_LAST = BW'(C_NO_CFG_BITS - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(C_NO_REGS - 1);

    tx_state_e                state_q, state_d;
    logic [15:0]              s_q, s_d;
    logic [15:0]              slot_q, slot_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [CW-1:0]            cyc_q, cyc_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [C_NO_CFG_BITS-1:0] sh_q, sh_d;
    logic                     start_q;
    logic                     start_rise;
    logic                     slot_end;
    logic                     slot_wrap;
    logic                     rd_en;
    logic [DATA_W-1:0]        rd_data;

    cfg_reg_bank u_bank (
        .gclk    (CLOCK),
        .grst_n  (RESET),
        .we_a    (bus.WE_A),
        .add_a   (bus.ADD_A),
        .dat_a   (bus.DAT_A),
        .rd_en   (rd_en),
        .rd_addr (addr_q[1:0]),
        .rd_data (rd_data)
    );

    assign start_rise = bus.START & ~start_q;
    assign slot_end   = (s_q == slot_q - 16'd1);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            slot_q  <= MIN_SLOT;
            addr_q  <= '0;
            cyc_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            slot_q  <= slot_d;
            addr_q  <= addr_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            start_q <= bus.START;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        slot_d    = slot_q;
        addr_d    = addr_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        rd_en     = 1'b0;
        slot_wrap = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_rise) begin
                    state_d = ST_READ;
                    s_d     = '0;
                    addr_d  = '0;
                end
            end
            ST_READ: begin
                rd_en   = 1'b1;
                // Slot length is sampled once per word so a mid-burst change
                // only affects the next slot.
                slot_d  = (bus.LINE_PERIOD > MIN_SLOT) ? bus.LINE_PERIOD : MIN_SLOT;
                s_d     = s_q + 16'd1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sh_d    = C_NO_CFG_BITS'({{(HDR_W-ADDR_W){1'b0}}, addr_q, rd_data});
                cyc_d   = '0;
                bit_d   = '0;
                s_d     = s_q + 16'd1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                s_d   = s_q + 16'd1;
                cyc_d = cyc_q + CW'(1);
                if (cyc_q == BIT_LAST) begin
                    // Shift at end of the high phase: data moves on TX_CLK fall.
                    cyc_d = '0;
                    sh_d  = {sh_q[C_NO_CFG_BITS-2:0], 1'b0};
                    bit_d = bit_q + BW'(1);
                    if (bit_q == WORD_LAST) begin
                        state_d   = ST_GAP;
                        // Minimum-length slot has no gap: wrap straight away.
                        slot_wrap = slot_end;
                    end
                end
            end
            ST_GAP: begin
                s_d       = s_q + 16'd1;
                slot_wrap = slot_end;
            end
            default: state_d = ST_IDLE;
        endcase

        if (slot_wrap) begin
            s_d = '0;
            if (addr_q == LAST_ADDR) begin
                state_d = ST_DONE;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = ST_READ;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            bus.TX_OE  <= 1'b0;
            bus.TX_CLK <= 1'b0;
            bus.TX_DAT <= 1'b0;
            bus.TX_END <= 1'b0;
        end else begin
            bus.TX_OE  <= (state_q == ST_SHIFT);
            bus.TX_CLK <= (state_q == ST_SHIFT) && (cyc_q >= CLK_RISE);
            bus.TX_DAT <= (state_q == ST_SHIFT) && sh_q[C_NO_CFG_BITS-1];
            bus.TX_END <= (state_q == ST_DONE);
        end
    end

endmodule

// File: tb/tb_config_tx_link.sv
// ---------------------------------------------------------------------------
// tb_config_tx_link
// Scoreboard bench: stimulus pushes expected 24-bit words; a negedge monitor
// deserialises TX_DAT on TX_CLK rises while TX_OE is high, and on TX_OE fall
// pops and compares the word, its enable width, bit count and bit timing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_config_tx_link;

    localparam int LO       = 9;
    localparam int HI       = 10;
    localparam int NB       = 24;
    localparam int OE_LEN   = 456;   // 24 bits * 19 clocks
    localparam int MIN_SLOT = 458;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    config_tx_link_if bus();

    config_tx_link dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #10 CLOCK = ~CLOCK;

    int cyc = 0;
    initial forever @(posedge CLOCK) cyc++;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] exp_q[$];
    logic [15:0] model[4];
    int          exp_space = 0;
    bit          burst_new = 1'b0;
    int          words_done = 0;
    int          idle_err = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endfunction

    function automatic void reset_model();
        model[0] = 16'h8001;
        model[1] = 16'h4002;
        model[2] = 16'h2004;
        model[3] = 16'h1008;
    endfunction

    function automatic void push_model();
        for (int a = 0; a < 4; a++) exp_q.push_back({5'b0, 3'(a), model[a]});
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic        p_oe, p_ck, dat_rise;
        logic [23:0] word;
        int          lo_run, hi_run, nbits, oelen, terr, last_start;
        bit          have_last;
        p_oe = 0; p_ck = 0; dat_rise = 0; word = '0; have_last = 0;
        lo_run = 0; hi_run = 0; nbits = 0; oelen = 0; terr = 0; last_start = 0;
        forever begin
            @(negedge CLOCK);
            if (!RESET) begin
                p_oe = 0; p_ck = 0; have_last = 0;
            end else begin
                if (!bus.TX_OE && (bus.TX_CLK || bus.TX_DAT)) idle_err++;
                if (bus.TX_OE && !p_oe) begin
                    if (have_last && !burst_new) check("word_spacing", cyc - last_start, exp_space);
                    burst_new = 0; have_last = 1; last_start = cyc;
                    word = '0; nbits = 0; oelen = 0; terr = 0; lo_run = 0; hi_run = 0;
                end
                if (bus.TX_OE) begin
                    oelen++;
                    if (bus.TX_CLK && !p_ck) begin
                        if (lo_run != LO) terr++;
                        hi_run   = 0;
                        word     = {word[22:0], bus.TX_DAT};
                        nbits++;
                        dat_rise = bus.TX_DAT;
                    end
                    if (!bus.TX_CLK && p_ck) begin
                        if (hi_run != HI) terr++;
                        lo_run = 0;
                    end
                    if (bus.TX_CLK) begin
                        hi_run++;
                        if (bus.TX_DAT !== dat_rise) terr++;
                    end else begin
                        lo_run++;
                    end
                end else if (p_oe) begin
                    if (p_ck && hi_run != HI) terr++;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL extra_word: got 0x%06h, no word expected", word);
                    end else begin
                        check("word", word, exp_q.pop_front());
                    end
                    check("oe_cycles", oelen, OE_LEN);
                    check("bit_count", nbits, NB);
                    check("bit_timing_errs", terr, 0);
                    words_done++;
                end
                p_oe = bus.TX_OE;
                p_ck = bus.TX_CLK;
            end
        end
    end

    // ---------------- stimulus ----------------
    int t0;

    task automatic start_edge();
        @(negedge CLOCK);
        bus.START = 1'b1;
        burst_new = 1'b1;
        @(negedge CLOCK);
        t0 = cyc;               // cycle count at the edge-detecting clock
        @(negedge CLOCK);
        check("end_cleared", bus.TX_END, 0);
    endtask

    // Edge registered -> READ next cycle -> outputs one cycle behind state,
    // so TX_END shows 4*slot+1 clocks after the edge-detecting clock.
    task automatic wait_end(input string name, input int exp_lat);
        int n = 0;
        while (!bus.TX_END && n < exp_lat + 200) begin
            @(negedge CLOCK);
            n++;
        end
        check(name, bus.TX_END ? cyc - t0 : -1, exp_lat);
    endtask

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge CLOCK);
        bus.WE_A = 1'b1; bus.ADD_A = a; bus.DAT_A = d;
        if (a[0]) model[a[2:1]][15:8] = d;
        else      model[a[2:1]][7:0]  = d;
        @(negedge CLOCK);
        bus.WE_A = 1'b0;
    endtask

    initial begin
        int base, n;
        bus.START = 0; bus.LINE_PERIOD = 16'd4000; bus.WE_A = 0; bus.ADD_A = '0; bus.DAT_A = '0;
        reset_model();
        #5 RESET = 1'b0;
        repeat (4) @(negedge CLOCK);
        check("rst_tx_end", bus.TX_END, 0);
        check("rst_tx_dat", bus.TX_DAT, 0);
        check("rst_tx_clk", bus.TX_CLK, 0);
        check("rst_tx_oe",  bus.TX_OE,  0);
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);

        // 1: default burst, 4000-cycle slots
        exp_space = 4000;
        exp_q.push_back(24'h008001);
        exp_q.push_back(24'h014002);
        exp_q.push_back(24'h022004);
        exp_q.push_back(24'h031008);
        start_edge();
        bus.START = 0;
        wait_end("t1_end_latency", 4 * 4000 + 1);
        repeat (10) @(negedge CLOCK);

        // 3: host byte writes into word 1, 500-cycle slots
        host_write(3'd3, 8'hAB);
        host_write(3'd2, 8'hCD);
        bus.LINE_PERIOD = 16'd500;
        exp_space = 500;
        exp_q.push_back(24'h008001);
        exp_q.push_back(24'h01ABCD);
        exp_q.push_back(24'h022004);
        exp_q.push_back(24'h031008);
        start_edge();
        bus.START = 0;
        wait_end("t3_end_latency", 4 * 500 + 1);

        // 4: LINE_PERIOD below minimum; bank contents kept from test 3
        bus.LINE_PERIOD = 16'd100;
        exp_space = MIN_SLOT;
        push_model();
        start_edge();
        bus.START = 0;
        wait_end("t4_end_latency", 4 * MIN_SLOT + 1);

        // 5: long START high, short drop, re-raise; then a mid-burst edge
        push_model();
        start_edge();
        wait_end("t5a_end_latency", 4 * MIN_SLOT + 1);
        while (cyc - t0 < 2400) @(negedge CLOCK);
        check("t5_end_held", bus.TX_END, 1);
        bus.START = 0;
        repeat (48) @(negedge CLOCK);
        push_model();
        start_edge();
        repeat (100) @(negedge CLOCK);
        bus.START = 0;
        repeat (100) @(negedge CLOCK);
        bus.START = 1;          // mid-burst edge: must not restart or queue a burst
        repeat (50) @(negedge CLOCK);
        bus.START = 0;
        wait_end("t5b_end_latency", 4 * MIN_SLOT + 1);
        repeat (1000) @(negedge CLOCK);
        check("t5_end_still_set", bus.TX_END, 1);
        check("t5_queue_drained", exp_q.size(), 0);

        // 6: reset during word 2 aborts; fresh burst afterwards from addr 0
        bus.LINE_PERIOD = 16'd4000;
        exp_space = 4000;
        push_model();
        base = words_done;
        start_edge();
        bus.START = 0;
        n = 0;
        while (!(words_done == base + 1 && bus.TX_OE) && n < 10000) begin
            @(negedge CLOCK);
            n++;
        end
        check("t6_in_word2", (words_done - base) * 2 + int'(bus.TX_OE), 3);
        repeat (100) @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        check("t6_abort_oe",  bus.TX_OE,  0);
        check("t6_abort_clk", bus.TX_CLK, 0);
        check("t6_abort_dat", bus.TX_DAT, 0);
        check("t6_abort_end", bus.TX_END, 0);
        exp_q.delete();
        reset_model();
        repeat (5) @(negedge CLOCK);
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        bus.LINE_PERIOD = 16'd600;
        exp_space = 600;
        push_model();
        base = words_done;
        start_edge();
        bus.START = 0;
        wait_end("t6_end_latency", 4 * 600 + 1);
        repeat (10) @(negedge CLOCK);
        check("t6_words_after_reset", words_done - base, 4);
        check("queue_drained", exp_q.size(), 0);
        check("idle_lines_quiet", idle_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
